// File: rtl/irq_timer.sv
// Machine timer/software/external interrupt source: mtime, mtimecmp, MSIP and ext_irq sync.
// Optional mtime prescaler enabled by defining MTIME_PRESCALE_EN (adds PRESCALE at addr 5).
module irq_timer #(
    parameter int          SYNC_STAGES  = 2,
    parameter logic [15:0] RST_PRESCALE = 16'd0
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    input  logic        ext_irq_in,
    output logic [63:0] mtime,
    output logic        mtip,
    output logic        msip,
    output logic        meip
);

    logic [63:0]            r_mtime;
    logic [63:0]            r_mtimecmp;
    logic                   r_msip;
    logic                   r_mtip;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_ack;
    logic                   r_err;
    logic [31:0]            r_rdata;

    logic                   w_wr;
    logic                   w_tick;
    logic [31:0]            w_rdata;
    logic                   w_unmapped;

    assign w_wr = req & we;

`ifdef MTIME_PRESCALE_EN
    logic [15:0] r_prescale;
    logic [15:0] r_pcnt;

    assign w_tick = (r_pcnt == r_prescale);

    // A PRESCALE write restarts the divider so the new period starts cleanly.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_prescale <= RST_PRESCALE;
            r_pcnt     <= 16'd0;
        end else if (w_wr && addr == 3'd5) begin
            r_prescale <= wdata[15:0];
            r_pcnt     <= 16'd0;
        end else if (w_tick) begin
            r_pcnt     <= 16'd0;
        end else begin
            r_pcnt     <= r_pcnt + 16'd1;
        end
    end
`else
    logic w_unused;

    assign w_unused = ^RST_PRESCALE;
    assign w_tick   = 1'b1;
`endif

    always_comb begin
        w_rdata    = 32'd0;
        w_unmapped = 1'b0;
        case (addr)
            3'd0: w_rdata = r_mtime[31:0];
            3'd1: w_rdata = r_mtime[63:32];
            3'd2: w_rdata = r_mtimecmp[31:0];
            3'd3: w_rdata = r_mtimecmp[63:32];
            3'd4: w_rdata = {31'd0, r_msip};
`ifdef MTIME_PRESCALE_EN
            3'd5: w_rdata = {16'd0, r_prescale};
`endif
            default: w_unmapped = 1'b1;
        endcase
    end

    // A write to either mtime half freezes the other half and drops that cycle's tick.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_mtime <= 64'd0;
        end else if (w_wr && addr == 3'd0) begin
            r_mtime[31:0] <= wdata;
        end else if (w_wr && addr == 3'd1) begin
            r_mtime[63:32] <= wdata;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_msip     <= 1'b0;
        end else if (w_wr) begin
            case (addr)
                3'd2:    r_mtimecmp[31:0]  <= wdata;
                3'd3:    r_mtimecmp[63:32] <= wdata;
                3'd4:    r_msip            <= wdata[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_mtip <= 1'b0;
        end else begin
            r_mtip <= (r_mtime >= r_mtimecmp);
        end
    end

    // Access response: one-cycle ack, read data captured from the request cycle.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ack   <= req;
            r_err   <= req & w_unmapped;
            r_rdata <= (req && !we) ? w_rdata : 32'd0;
        end
    end

    generate
        if (SYNC_STAGES > 1) begin : g_sync
            always_ff @(posedge clk_in) begin
                if (reset_in) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], ext_irq_in};
                end
            end
        end else begin : g_sync1
            always_ff @(posedge clk_in) begin
                if (reset_in) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= ext_irq_in;
                end
            end
        end
    endgenerate

    assign ack   = r_ack;
    assign err   = r_err;
    assign rdata = r_rdata;
    assign mtime = r_mtime;
    assign mtip  = r_mtip;
    assign msip  = r_msip;
    assign meip  = r_sync[SYNC_STAGES-1];

endmodule

// File: tb/tb_irq_timer.sv
// Directed self-checking bench for irq_timer (register port, counter, compare, sync, prescale).
module tb_irq_timer;

    localparam int SYNC = 2;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        ext_irq_in = 1'b0;
    logic [63:0] mtime;
    logic        mtip;
    logic        msip;
    logic        meip;

    int n_checks = 0;
    int n_errors = 0;

    irq_timer #(.SYNC_STAGES(SYNC), .RST_PRESCALE(16'd0)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ack(ack), .err(err), .rdata(rdata), .ext_irq_in(ext_irq_in),
        .mtime(mtime), .mtip(mtip), .msip(msip), .meip(meip)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // One register access; returns the response sampled in the ack cycle.
    task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                       output logic ak, output logic er, output logic [31:0] rd);
        req = 1'b1; we = w; addr = a; wdata = d;
        cyc(1);
        req = 1'b0; we = 1'b0;
        ak = ack; er = err; rd = rdata;
    endtask

    task automatic test_reset;
        reset_in = 1'b1;
        cyc(3);
        n_checks++;
        if (mtime !== 64'd0 || mtip !== 1'b0 || msip !== 1'b0 || meip !== 1'b0 ||
            ack !== 1'b0 || err !== 1'b0 || rdata !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_state: got mtime=%0h mtip=%b msip=%b meip=%b ack=%b err=%b rdata=%0h, required all zero",
                     mtime, mtip, msip, meip, ack, err, rdata);
        end
        reset_in = 1'b0;
        cyc(10);
        n_checks++;
        if (mtime !== 64'd10) begin
            n_errors++;
            $display("FAIL free_run_mtime: got %0d required 10", mtime);
        end
        n_checks++;
        if (mtip !== 1'b0 || msip !== 1'b0 || meip !== 1'b0) begin
            n_errors++;
            $display("FAIL free_run_irqs: got mtip=%b msip=%b meip=%b required 000", mtip, msip, meip);
        end
    endtask

    task automatic test_compare;
        logic ak, er;
        logic [31:0] rd;
        int guard;
        bus(1'b1, 3'd3, 32'd0, ak, er, rd);
        bus(1'b1, 3'd2, 32'd40, ak, er, rd);
        guard = 0;
        while (mtime !== 64'd40 && guard < 100) begin
            cyc(1);
            guard++;
        end
        n_checks++;
        if (mtime !== 64'd40) begin
            n_errors++;
            $display("FAIL cmp_reach40: got mtime=%0d required 40", mtime);
        end
        n_checks++;
        if (mtip !== 1'b0) begin
            n_errors++;
            $display("FAIL cmp_mtip_lag: got %b required 0", mtip);
        end
        cyc(1);
        n_checks++;
        if (mtip !== 1'b1) begin
            n_errors++;
            $display("FAIL cmp_mtip_rise: got %b required 1", mtip);
        end
        bus(1'b0, 3'd2, 32'd0, ak, er, rd);
        n_checks++;
        if (rd !== 32'd40 || mtip !== 1'b1) begin
            n_errors++;
            $display("FAIL cmp_read_keeps: got rdata=%0d mtip=%b required 40 1", rd, mtip);
        end
        bus(1'b1, 3'd2, 32'd1000, ak, er, rd);
        n_checks++;
        if (ak !== 1'b1 || mtip !== 1'b1) begin
            n_errors++;
            $display("FAIL cmp_raise_ack: got ack=%b mtip=%b required 1 1", ak, mtip);
        end
        cyc(1);
        n_checks++;
        if (mtip !== 1'b0) begin
            n_errors++;
            $display("FAIL cmp_mtip_fall: got %b required 0", mtip);
        end
    endtask

    task automatic test_carry_wrap;
        logic ak, er;
        logic [31:0] rd;
        bus(1'b1, 3'd0, 32'hFFFF_FFFE, ak, er, rd);
        bus(1'b1, 3'd1, 32'd0, ak, er, rd);
        n_checks++;
        if (mtime !== 64'h0000_0000_FFFF_FFFE) begin
            n_errors++;
            $display("FAIL carry_hold: got %h required 00000000fffffffe", mtime);
        end
        cyc(2);
        n_checks++;
        if (mtime !== 64'h0000_0001_0000_0000) begin
            n_errors++;
            $display("FAIL carry_mtime: got %h required 0000000100000000", mtime);
        end
        bus(1'b0, 3'd0, 32'd0, ak, er, rd);
        n_checks++;
        if (rd !== 32'd0) begin
            n_errors++;
            $display("FAIL carry_read_lo: got %h required 0", rd);
        end
        bus(1'b0, 3'd1, 32'd0, ak, er, rd);
        n_checks++;
        if (rd !== 32'd1) begin
            n_errors++;
            $display("FAIL carry_read_hi: got %h required 1", rd);
        end
        bus(1'b1, 3'd0, 32'hFFFF_FFFF, ak, er, rd);
        bus(1'b1, 3'd1, 32'hFFFF_FFFF, ak, er, rd);
        n_checks++;
        if (mtime !== 64'hFFFF_FFFF_FFFF_FFFF || mtip !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_setup: got mtime=%h mtip=%b required all-ones 1", mtime, mtip);
        end
        cyc(1);
        n_checks++;
        if (mtime !== 64'd0) begin
            n_errors++;
            $display("FAIL wrap_mtime: got %h required 0", mtime);
        end
        cyc(1);
        n_checks++;
        if (mtip !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_mtip_fall: got %b required 0", mtip);
        end
    endtask

    task automatic test_regport;
        logic ak, er;
        logic [31:0] rd;
        n_checks++;
        if (msip !== 1'b0) begin
            n_errors++;
            $display("FAIL msip_initial: got %b required 0", msip);
        end
        bus(1'b1, 3'd4, 32'hFFFF_FFFF, ak, er, rd);
        n_checks++;
        if (ak !== 1'b1 || er !== 1'b0 || msip !== 1'b1) begin
            n_errors++;
            $display("FAIL msip_write: got ack=%b err=%b msip=%b required 1 0 1", ak, er, msip);
        end
        bus(1'b0, 3'd4, 32'd0, ak, er, rd);
        n_checks++;
        if (rd !== 32'd1 || er !== 1'b0) begin
            n_errors++;
            $display("FAIL msip_read: got rdata=%h err=%b required 1 0", rd, er);
        end
        cyc(1);
        n_checks++;
        if (ack !== 1'b0 || rdata !== 32'd0) begin
            n_errors++;
            $display("FAIL idle_resp: got ack=%b rdata=%h required 0 0", ack, rdata);
        end
        bus(1'b0, 3'd7, 32'd0, ak, er, rd);
        n_checks++;
        if (ak !== 1'b1 || er !== 1'b1 || rd !== 32'd0) begin
            n_errors++;
            $display("FAIL unmapped_read7: got ack=%b err=%b rdata=%h required 1 1 0", ak, er, rd);
        end
        bus(1'b1, 3'd6, 32'h1234_5678, ak, er, rd);
        n_checks++;
        if (ak !== 1'b1 || er !== 1'b1) begin
            n_errors++;
            $display("FAIL unmapped_write6: got ack=%b err=%b required 1 1", ak, er);
        end
        bus(1'b0, 3'd5, 32'd0, ak, er, rd);
`ifdef MTIME_PRESCALE_EN
        n_checks++;
        if (er !== 1'b0 || rd !== 32'd0) begin
            n_errors++;
            $display("FAIL prescale_read: got err=%b rdata=%h required 0 0", er, rd);
        end
`else
        n_checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            n_errors++;
            $display("FAIL unmapped_read5: got err=%b rdata=%h required 1 0", er, rd);
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [2:0]  a_list [4] = '{3'd4, 3'd2, 3'd3, 3'd7};
        logic        e_list [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] d_list [4] = '{32'd1, 32'd1000, 32'd0, 32'd0};
        int acks = 0;
        for (int i = 0; i < 4; i++) begin
            req = 1'b1; we = 1'b0; addr = a_list[i];
            cyc(1);
            if (i == 3) req = 1'b0;
            if (ack === 1'b1) acks++;
            n_checks++;
            if (err !== e_list[i] || rdata !== d_list[i]) begin
                n_errors++;
                $display("FAIL b2b_resp%0d: got err=%b rdata=%h required %b %h",
                         i, err, rdata, e_list[i], d_list[i]);
            end
        end
        cyc(1);
        n_checks++;
        if (acks !== 4 || ack !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_acks: got %0d pulses trailing ack=%b required 4 0", acks, ack);
        end
    endtask

    task automatic test_ext_sync;
        logic exp;
        ext_irq_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            if (k == 5) ext_irq_in = 1'b0;
            exp = (k >= SYNC && k < SYNC + 5);
            n_checks++;
            if (meip !== exp) begin
                n_errors++;
                $display("FAIL meip_cycle%0d: got %b required %b", k, meip, exp);
            end
        end
    endtask

    task automatic test_reset_ext;
        ext_irq_in = 1'b1;
        cyc(SYNC + 1);
        n_checks++;
        if (meip !== 1'b1) begin
            n_errors++;
            $display("FAIL meip_pre_reset: got %b required 1", meip);
        end
        reset_in = 1'b1;
        req = 1'b1; we = 1'b1; addr = 3'd4; wdata = 32'd1;
        cyc(1);
        req = 1'b0; we = 1'b0;
        n_checks++;
        if (meip !== 1'b0 || ack !== 1'b0 || msip !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_access: got meip=%b ack=%b msip=%b required 0 0 0", meip, ack, msip);
        end
        cyc(1);
        n_checks++;
        if (meip !== 1'b0 || ack !== 1'b0 || mtime !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_hold: got meip=%b ack=%b mtime=%h required 0 0 0", meip, ack, mtime);
        end
        reset_in = 1'b0;
        ext_irq_in = 1'b0;
        cyc(SYNC + 1);
    endtask

    task automatic test_prescale;
`ifdef MTIME_PRESCALE_EN
        logic ak, er;
        logic [31:0] rd;
        bus(1'b1, 3'd5, 32'd3, ak, er, rd);
        bus(1'b1, 3'd0, 32'd0, ak, er, rd);
        cyc(2);
        n_checks++;
        if (mtime !== 64'd0) begin
            n_errors++;
            $display("FAIL prescale_hold: got %0d required 0", mtime);
        end
        cyc(1);
        n_checks++;
        if (mtime !== 64'd1) begin
            n_errors++;
            $display("FAIL prescale_first_tick: got %0d required 1", mtime);
        end
        cyc(17);
        n_checks++;
        if (mtime !== 64'd5) begin
            n_errors++;
            $display("FAIL prescale_20cyc: got %0d required 5", mtime);
        end
        bus(1'b0, 3'd5, 32'd0, ak, er, rd);
        n_checks++;
        if (rd !== 32'd3 || er !== 1'b0) begin
            n_errors++;
            $display("FAIL prescale_readback: got rdata=%h err=%b required 3 0", rd, er);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_compare();
        test_carry_wrap();
        test_regport();
        test_back_to_back();
        test_ext_sync();
        test_reset_ext();
        test_prescale();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/irq_timer.md
# irq_timer

Machine-level interrupt source block that produces the `mtip`, `msip` and `meip` pending bits feeding the machine CSR `mip` register. The CSR file and the mode/interrupt logic consume them. It holds the 64-bit `mtime` counter, the `mtimecmp` compare register and the software-interrupt register, all behind a small word-addressed register port. It also synchronizes the asynchronous external interrupt line into the `clk_in` domain.

## Interface
- Clocking and reset (already decided): one clock; reset is synchronous and active-high. The clock port is `clk_in` and the reset port is `reset_in`.

**Parameters**
- `SYNC_STAGES`, default 2: flop stages on `ext_irq_in`; minimum 2.
- `RST_PRESCALE`, default 16'd0: reset value of PRESCALE (only used with `MTIME_PRESCALE_EN`).

**Ports**
- `clk_in`  in  1  system clock.
- `reset_in`  in  1  synchronous, active-high reset.
- `req`  in  1  register access request, one-cycle pulse.
- `we`  in  1  1 = write, 0 = read; qualified by `req`.
- `addr`  in  3  word index.
- `wdata`  in  32  write data.
- `ack`  out  1  access complete.
- `err`  out  1  unmapped address; valid with `ack`.
- `rdata`  out  32  read data; valid with `ack`, else 0.
- `ext_irq_in`  in  1  asynchronous external interrupt, level, active-high.
- `mtime`  out  64  current counter value, for the `time`/`timeh` CSRs.
- `mtip`  out  1  machine timer interrupt pending.
- `msip`  out  1  machine software interrupt pending.
- `meip`  out  1  machine external interrupt pending.

## Operation
**Register map** (addr: register)
- 0: MTIME_LO
- 1: MTIME_HI
- 2: MTIMECMP_LO
- 3: MTIMECMP_HI
- 4: MSIP — bit 0 is R/W; bits 31:1 read 0 and ignore writes.
- 5: PRESCALE — bits 15:0 R/W; only with `MTIME_PRESCALE_EN`.
- 5–7 otherwise: unmapped. Writes are ignored, reads return 0, `err`=1.

**Counter**
- `mtime` increments by 1 on each tick, wrapping 0xFFFF_FFFF_FFFF_FFFF → 0.
- Carry from LO into HI happens in the same cycle as the LO increment.

**Write to MTIME_LO or MTIME_HI coincident with a tick**
- The written half takes `wdata`.
- The unwritten half holds its value; any carry that cycle is dropped.
- Counting resumes on the next tick.

**Compare**
- `mtip` = registered (`mtime` >= `mtimecmp`), using an unsigned 64-bit compare.
- `mtip` clears only when `mtimecmp` is raised above `mtime`, or when `mtime` wraps. It is not cleared by a read.

**Software interrupt**
- `msip` = MSIP[0].

**External interrupt**
- `meip` = `ext_irq_in` after `SYNC_STAGES` flops. It is level-sensitive, with no latching.

## Timing
**Reset values**
- `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, MSIP=0, PRESCALE=`RST_PRESCALE`, prescale counter=0.
- Sync flops=0.
- `mtip`=0, `msip`=0, `meip`=0, `ack`=0, `err`=0, `rdata`=0.
- Reset asserted mid-access drops that access: no `ack` is produced.

**Register access**
- `ack` and `err` assert exactly 1 cycle after `req`, for 1 cycle.
- Back-to-back `req` on consecutive cycles is legal and produces `ack` on each following cycle.
- Write data takes effect at the clock edge that raises `ack`.
- Read data reflects register state at the `req` cycle.

**Interrupt latencies**
- `mtip` lags the compare condition by 1 cycle.
- `msip` asserts in the `ack` cycle of the write.
- `meip` lags `ext_irq_in` by `SYNC_STAGES` cycles (±1 due to asynchronous sampling).

**64-bit access**
- There is no atomic 64-bit access; software uses the HI/LO/HI retry sequence.
- Software writes `mtimecmp` LO=all-ones first to avoid a spurious `mtip`.

## Configuration
**`MTIME_PRESCALE_EN` defined**
- A 16-bit prescale counter increments every cycle.
- When the counter equals PRESCALE, a tick is issued and the counter returns to 0.
- PRESCALE=0 gives a tick every cycle. PRESCALE=N gives a tick every N+1 cycles.
- A write to PRESCALE also clears the prescale counter.
- addr 5 is mapped.

**`MTIME_PRESCALE_EN` undefined**
- A tick occurs every cycle.
- No prescale logic exists.
- addr 5 is unmapped (`err`=1, read returns 0).

## Test plan
- **Reset and free-run:** release reset, run 10 cycles with no access → `mtime`=10 (prescale 0), `mtip`=0, `msip`=0, `meip`=0.
- **Compare:** write MTIMECMP_HI=0, then MTIMECMP_LO=40 → `mtip` rises the cycle after `mtime` reaches 40. Write MTIMECMP_LO=1000 → `mtip` falls 1 cycle after that write's `ack`.
- **Carry and wrap:**
  - Write MTIME_LO=0xFFFF_FFFE, MTIME_HI=0 → two ticks later MTIME_HI reads 1 and MTIME_LO reads 0.
  - Write all-ones to both halves → the counter wraps to 0, and `mtip` falls if `mtimecmp` > 0.
- **Register port:**
  - Write MSIP=0xFFFF_FFFF → `msip`=1 and a read returns 0x1.
  - Read addr 7 → `err`=1, `rdata`=0.
  - Issue 4 back-to-back reqs → 4 consecutive `ack` pulses.
- **External sync:**
  - Pulse `ext_irq_in` high for 5 cycles → `meip` high for 5 cycles, starting `SYNC_STAGES` cycles later.
  - Assert `reset_in` with `ext_irq_in`=1 → `meip`=0 during reset.
- **Prescale (`MTIME_PRESCALE_EN` only):** write PRESCALE=3, then MTIME_LO=0 → `mtime` advances 1 per 4 cycles and reads 5 after 20 cycles.
